// File: rtl/adder_3bit.sv
// Registered unsigned W-bit adder with a (W+1)-bit sum, valid flag and carry copy.
// Optional saturating carry counter is enabled by defining ADDER3BIT_CARRY_CNT_EN.
module adder_3bit #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] sayi1,
  input  logic [W-1:0] sayi2,
  output logic [W:0]   toplam,
  output logic         out_valid,
`ifdef ADDER3BIT_CARRY_CNT_EN
  output logic         carry,
  output logic [7:0]   carry_cnt
`else
  output logic         carry
`endif
);

  // Zero-extend both operands so the sum can never wrap.
  function automatic logic [W:0] wide_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [W:0] sum_s;

  // Combinational sum of the current operands.
  always_comb begin
    sum_s = wide_add(sayi1, sayi2);
  end

  // Result registers: reset wins, idle edges hold the sum and drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      toplam    <= {(W+1){1'b0}};
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      toplam    <= sum_s;
      carry     <= sum_s[W];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef ADDER3BIT_CARRY_CNT_EN
  // Counts accepted sums with a carry out, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= 8'd0;
    end else if (in_valid && sum_s[W] && (carry_cnt != 8'd255)) begin
      carry_cnt <= carry_cnt + 8'd1;
    end else begin
      carry_cnt <= carry_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_adder_3bit.sv
// Scoreboard bench for adder_3bit: a posedge reference model queues expected sums,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_adder_3bit;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sayi1 = '0;
  logic [W-1:0] sayi2 = '0;
  logic [W:0]   toplam;
  logic         out_valid;
  logic         carry;
`ifdef ADDER3BIT_CARRY_CNT_EN
  logic [7:0]   carry_cnt;
`endif

  int errors = 0;
  int checks = 0;

  int q[$];
  int hold_sum = 0;
  logic exp_valid = 1'b0;
  int exp_cnt = 0;
  logic armed = 1'b0;

  adder_3bit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sayi1     (sayi1),
    .sayi2     (sayi2),
    .toplam    (toplam),
    .out_valid (out_valid),
`ifdef ADDER3BIT_CARRY_CNT_EN
    .carry     (carry),
    .carry_cnt (carry_cnt)
`else
    .carry     (carry)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the sum is plain integer addition; carry means sum >= 2^W.
  always @(posedge clk) begin
    if (rst) begin
      exp_valid <= 1'b0;
      hold_sum  <= 0;
      exp_cnt   <= 0;
      armed     <= 1'b1;
    end else if (in_valid) begin
      q.push_back(int'(sayi1) + int'(sayi2));
      hold_sum  <= int'(sayi1) + int'(sayi2);
      exp_valid <= 1'b1;
      if ((int'(sayi1) + int'(sayi2)) >= (1 << W) && exp_cnt < 255)
        exp_cnt <= exp_cnt + 1;
    end else begin
      exp_valid <= 1'b0;
    end
  end

  // Monitor: pop on out_valid, otherwise expect the previous result to be held.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: toplam=%0d with empty scoreboard at %0t", toplam, $time);
        end else begin
          int e;
          e = q.pop_front();
          checks++;
          if (int'(toplam) != e || carry !== (e >= (1 << W))) begin
            errors++;
            $display("FAIL sum: got toplam=%0d carry=%b expected toplam=%0d carry=%b at %0t",
                     toplam, carry, e, (e >= (1 << W)), $time);
          end
        end
      end else begin
        checks++;
        if (int'(toplam) != hold_sum || carry !== (hold_sum >= (1 << W))) begin
          errors++;
          $display("FAIL hold: got toplam=%0d carry=%b expected toplam=%0d carry=%b at %0t",
                   toplam, carry, hold_sum, (hold_sum >= (1 << W)), $time);
        end
        if (q.size() != 0) begin
          errors++;
          $display("FAIL missing_output: %0d results pending, out_valid=0 at %0t", q.size(), $time);
          q.delete();
        end
      end
`ifdef ADDER3BIT_CARRY_CNT_EN
      checks++;
      if (int'(carry_cnt) != exp_cnt) begin
        errors++;
        $display("FAIL carry_cnt: got %0d expected %0d at %0t", carry_cnt, exp_cnt, $time);
      end
`endif
    end
  end

  task automatic drive(input logic r, input logic v, input int a, input int b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    sayi1    = a[W-1:0];
    sayi2    = b[W-1:0];
  endtask

  int dir_a[8] = '{0, 5, 5, 3, 6, 5, 7, 1};
  int dir_b[8] = '{0, 0, 4, 3, 1, 2, 7, 1};

  initial begin
    // Reset with live operands: they must be discarded.
    drive(1'b1, 1'b1, 7, 7);
    drive(1'b1, 1'b1, 7, 7);

    // Directed sums, with a 3-cycle idle hold after (5,4).
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, dir_a[i], dir_b[i]);
      if (i == 2)
        for (int h = 0; h < 3; h++) drive(1'b0, 1'b0, 2, 2);
    end

    // Exhaustive back-to-back.
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        drive(1'b0, 1'b1, a, b);

    // Reset mid-stream: (7,7) coincides with rst and must never appear.
    drive(1'b0, 1'b1, 6, 1);
    drive(1'b1, 1'b1, 7, 7);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1, 2);

    // Randomized traffic with occasional resets and idle gaps.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
            $urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1));

`ifdef ADDER3BIT_CARRY_CNT_EN
    drive(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 7, 7);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
`endif

    drive(1'b0, 1'b0, 3, 3);
    drive(1'b0, 1'b0, 3, 3);
    drive(1'b0, 1'b0, 3, 3);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
